// File: rtl/trng_pkg.sv
// Shared types and defaults for the TRNG controller: FSM state encoding,
// default parameter values and a counter-width helper.
package trng_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WARMUP  = 3'd1,
    ST_COLLECT = 3'd2,
    ST_HOLD    = 3'd3,
    ST_ERROR   = 3'd4
  } trng_state_t;

  localparam int DEF_WIDTH         = 32;
  localparam int DEF_SAMPLE_DIV    = 4;
  localparam int DEF_WARMUP_CYCLES = 256;
  localparam int DEF_REP_LIMIT     = 32;

  // Width of a counter that holds 0..limit-1; never narrower than one bit.
  function automatic int cnt_w(input int limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/trng_ctrl_if.sv
// Output word stream of the TRNG controller.
// valid_o/ready_i: a word moves when both are 1 at a clk edge; once valid_o
// rises, data_o and valid_o stay stable until that transfer, and ready_i is
// ignored while valid_o is 0.
interface trng_ctrl_if #(
  parameter int WIDTH = trng_pkg::DEF_WIDTH
);
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic             ready_i;

  modport master (output data_o, output valid_o, input ready_i);
  modport slave  (input data_o, input valid_o, output ready_i);
endinterface

// File: rtl/trng_vn_debias.sv
// Von Neumann debiaser: pairs consecutive raw samples (first, second);
// 01 emits 0, 10 emits 1, 00 and 11 are dropped.
module trng_vn_debias (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic strobe,
  input  logic raw_bit,
  output logic bit_valid,
  output logic bit_val
);

  logic have_first;
  logic first;

  // The emitted bit equals the first sample of a differing pair.
  assign bit_valid = strobe && have_first && (first != raw_bit);
  assign bit_val   = first;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      have_first <= 1'b0;
      first      <= 1'b0;
    end else if (clear) begin
      have_first <= 1'b0;
    end else if (strobe) begin
      if (have_first) begin
        have_first <= 1'b0;
      end else begin
        have_first <= 1'b1;
        first      <= raw_bit;
      end
    end
  end

endmodule

// File: rtl/trng_ctrl.sv
// TRNG controller: warms up the oscillator bank, samples it on a divided
// strobe, debiases into LSB-first words and runs a repetition health test.
module trng_ctrl
  import trng_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SAMPLE_DIV    = DEF_SAMPLE_DIV,
  parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
  parameter int REP_LIMIT     = DEF_REP_LIMIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        clear_err,
  input  logic        trng_bit,
  output logic        trng_en,
  output logic        error_o,
  trng_ctrl_if.master out_if,
  output trng_state_t dbg_state
);

  localparam int WARM_W = cnt_w(WARMUP_CYCLES);
  localparam int DIV_W  = cnt_w(SAMPLE_DIV);
  localparam int REP_W  = cnt_w(REP_LIMIT);
  localparam int BIT_W  = cnt_w(WIDTH);

  trng_state_t      state;
  logic [WARM_W-1:0] warm_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic [REP_W-1:0]  rep_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              have_prev;
  logic              prev_bit;
  logic [WIDTH-1:0]  word;
  logic [WIDTH-1:0]  next_word;
  logic [WIDTH-1:0]  data_q;
  logic              valid_q;

  logic strobe;
  logic rep_hit;
  logic bit_valid;
  logic bit_val;
  logic word_done;
  logic go_idle;

  assign strobe    = (state == ST_COLLECT) && (div_cnt == DIV_W'(SAMPLE_DIV - 1));
  // rep_cnt counts repeats after the first sample of a run, so REP_LIMIT-2
  // repeats plus one more equal sample is a run of REP_LIMIT.
  assign rep_hit   = strobe && have_prev && (trng_bit == prev_bit) &&
                     (rep_cnt == REP_W'(REP_LIMIT - 2));
  assign word_done = bit_valid && (bit_cnt == BIT_W'(WIDTH - 1));
  assign go_idle   = !enable && ((state == ST_WARMUP) || (state == ST_COLLECT) ||
                                 (state == ST_HOLD));

  always_comb begin
    next_word          = word;
    next_word[bit_cnt] = bit_val;
  end

  trng_vn_debias u_debias (
    .clk       (clk),
    .rst       (rst),
    .clear     (state != ST_COLLECT),
    .strobe    (strobe),
    .raw_bit   (trng_bit),
    .bit_valid (bit_valid),
    .bit_val   (bit_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      trng_en   <= 1'b0;
      error_o   <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      word      <= '0;
      warm_cnt  <= '0;
      div_cnt   <= '0;
      rep_cnt   <= '0;
      bit_cnt   <= '0;
      have_prev <= 1'b0;
      prev_bit  <= 1'b0;
    end else if (go_idle) begin
      state     <= ST_IDLE;
      trng_en   <= 1'b0;
      valid_q   <= 1'b0;
      word      <= '0;
      warm_cnt  <= '0;
      div_cnt   <= '0;
      rep_cnt   <= '0;
      bit_cnt   <= '0;
      have_prev <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          trng_en <= 1'b0;
          valid_q <= 1'b0;
          if (enable) begin
            state    <= ST_WARMUP;
            trng_en  <= 1'b1;
            warm_cnt <= '0;
          end
        end
        ST_WARMUP: begin
          if (warm_cnt == WARM_W'(WARMUP_CYCLES - 1)) begin
            state     <= ST_COLLECT;
            warm_cnt  <= '0;
            div_cnt   <= '0;
            rep_cnt   <= '0;
            bit_cnt   <= '0;
            have_prev <= 1'b0;
            word      <= '0;
          end else begin
            warm_cnt <= warm_cnt + 1'b1;
          end
        end
        ST_COLLECT: begin
          if (strobe) begin
            div_cnt <= '0;
            if (!have_prev) begin
              have_prev <= 1'b1;
              prev_bit  <= trng_bit;
              rep_cnt   <= '0;
            end else if (trng_bit != prev_bit) begin
              prev_bit <= trng_bit;
              rep_cnt  <= '0;
            end else if (!rep_hit) begin
              rep_cnt <= rep_cnt + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
          // The health trip wins over a word completing on the same strobe.
          if (rep_hit) begin
            state   <= ST_ERROR;
            trng_en <= 1'b0;
            error_o <= 1'b1;
            word    <= '0;
            bit_cnt <= '0;
          end else if (word_done) begin
            state   <= ST_HOLD;
            data_q  <= next_word;
            valid_q <= 1'b1;
            word    <= '0;
            bit_cnt <= '0;
          end else if (bit_valid) begin
            word    <= next_word;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (out_if.ready_i) begin
            state     <= ST_COLLECT;
            valid_q   <= 1'b0;
            div_cnt   <= '0;
            rep_cnt   <= '0;
            bit_cnt   <= '0;
            have_prev <= 1'b0;
            word      <= '0;
          end
        end
        ST_ERROR: begin
          trng_en <= 1'b0;
          valid_q <= 1'b0;
          if (clear_err) begin
            state   <= ST_IDLE;
            error_o <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          trng_en <= 1'b0;
          valid_q <= 1'b0;
          error_o <= 1'b0;
        end
      endcase
    end
  end

  assign out_if.data_o  = data_q;
  assign out_if.valid_o = valid_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_trng_ctrl.sv
// Directed bench for trng_ctrl at default parameters: word vectors from a
// table plus hand-written warmup, hold, health-test, disable and reset cases.
module tb_trng_ctrl;
  import trng_pkg::*;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        clear_err;
  logic        trng_bit;
  logic        trng_en;
  logic        error_o;
  trng_state_t dbg_state;

  trng_ctrl_if #(.WIDTH(W)) sif ();

  trng_ctrl #(
    .WIDTH         (W),
    .SAMPLE_DIV    (4),
    .WARMUP_CYCLES (256),
    .REP_LIMIT     (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .clear_err (clear_err),
    .trng_bit  (trng_bit),
    .trng_en   (trng_en),
    .error_o   (error_o),
    .out_if    (sif),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] word;
    int           disc_every;
    int           hold_cycles;
    logic [W-1:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input trng_state_t exp);
    n_checks++;
    if (dbg_state !== exp) begin
      n_errors++;
      $display("FAIL %s: state got %s expected %s", name, dbg_state.name(), exp.name());
    end
  endtask

  // driver: one raw sample lasts exactly one divider period
  task automatic send_sample(input logic b);
    trng_bit = b;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Every sample of a word except the final one; discard pairs 00/11 are
  // inserted before bit i whenever i is a multiple of disc_every.
  task automatic feed_word(input logic [W-1:0] w, input int disc_every);
    logic d;
    for (int i = 0; i < W; i++) begin
      if (disc_every != 0 && (i % disc_every) == 0) begin
        d = ((i / disc_every) % 2) != 0;
        send_sample(d);
        send_sample(d);
      end
      send_sample(w[i]);
      if (i != W - 1) send_sample(~w[i]);
    end
  endtask

  // Called just after the edge that sampled enable=1; ends just after the
  // edge that enters COLLECT.
  task automatic do_warmup(input logic pulse_clr);
    if (pulse_clr) begin
      clear_err = 1'b1;
      @(posedge clk); #1;
      clear_err = 1'b0;
      check_state("clr_ignored_warmup", ST_WARMUP);
      repeat (254) @(posedge clk);
    end else begin
      repeat (255) @(posedge clk);
    end
    #1;
    check_state("warmup_last_cycle", ST_WARMUP);
    check("warmup_trng_en", W'(trng_en), W'(1));
    @(posedge clk); #1;
    check_state("collect_entry", ST_COLLECT);
  endtask

  // Finishes a word and checks it against the scoreboard.
  task automatic finish_word(input logic [W-1:0] w, input string tag);
    logic [W-1:0] exp;
    check({tag, "_valid_early"}, W'(sif.valid_o), W'(0));
    send_sample(~w[W-1]);
    exp = exp_q.pop_front();
    check({tag, "_valid"}, W'(sif.valid_o), W'(1));
    check({tag, "_data"}, sif.data_o, exp);
  endtask

  initial begin
    vecs[0] = '{word: 32'hFFFF_FFFF, disc_every: 0, hold_cycles: 0, exp_data: 32'hFFFF_FFFF};
    vecs[1] = '{word: 32'h0000_0000, disc_every: 0, hold_cycles: 0, exp_data: 32'h0000_0000};
    vecs[2] = '{word: 32'hA5A5_A5A5, disc_every: 0, hold_cycles: 5, exp_data: 32'hA5A5_A5A5};
    vecs[3] = '{word: 32'h1234_5678, disc_every: 4, hold_cycles: 0, exp_data: 32'h1234_5678};
    vecs[4] = '{word: 32'h8000_0001, disc_every: 8, hold_cycles: 3, exp_data: 32'h8000_0001};

    rst = 1'b1; enable = 1'b0; clear_err = 1'b0; trng_bit = 1'b0; sif.ready_i = 1'b0;
    repeat (3) @(posedge clk); #1;
    check_state("reset_state", ST_IDLE);
    check("reset_trng_en", W'(trng_en), W'(0));
    check("reset_valid", W'(sif.valid_o), W'(0));
    check("reset_error", W'(error_o), W'(0));
    check("reset_data", sif.data_o, W'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    check_state("idle_no_enable", ST_IDLE);

    // first word: alternating 0,1 samples, then a 100-cycle stall
    enable = 1'b1;
    @(posedge clk); #1;
    check("trng_en_rise", W'(trng_en), W'(1));
    check_state("warmup_entry", ST_WARMUP);
    do_warmup(1'b1);
    exp_q.push_back(32'h0000_0000);
    feed_word(32'h0000_0000, 0);
    finish_word(32'h0000_0000, "w_alt01");
    for (int c = 0; c < 100; c++) begin
      trng_bit = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("stall_valid", W'(sif.valid_o), W'(1));
      check("stall_data", sif.data_o, W'(0));
    end
    sif.ready_i = 1'b1;
    @(posedge clk); #1;
    check("stall_release_valid", W'(sif.valid_o), W'(0));
    check_state("stall_release_state", ST_COLLECT);

    for (int v = 0; v < 5; v++) begin
      sif.ready_i = (vecs[v].hold_cycles == 0);
      exp_q.push_back(vecs[v].exp_data);
      feed_word(vecs[v].word, vecs[v].disc_every);
      finish_word(vecs[v].word, $sformatf("vec%0d", v));
      for (int c = 0; c < vecs[v].hold_cycles; c++) begin
        @(posedge clk); #1;
        check("vec_hold_valid", W'(sif.valid_o), W'(1));
        check("vec_hold_data", sif.data_o, vecs[v].exp_data);
      end
      sif.ready_i = 1'b1;
      @(posedge clk); #1;
      check("vec_xfer_valid", W'(sif.valid_o), W'(0));
      check_state("vec_xfer_state", ST_COLLECT);
    end
    sif.ready_i = 1'b0;

    // repetition health test with trng_bit stuck at 1
    for (int s = 0; s < 31; s++) send_sample(1'b1);
    check("rep31_error", W'(error_o), W'(0));
    check_state("rep31_state", ST_COLLECT);
    send_sample(1'b1);
    check("rep32_error", W'(error_o), W'(1));
    check("rep32_trng_en", W'(trng_en), W'(0));
    check("rep32_valid", W'(sif.valid_o), W'(0));
    check_state("rep32_state", ST_ERROR);
    repeat (5) @(posedge clk); #1;
    check_state("error_sticky_enable", ST_ERROR);
    clear_err = 1'b1;
    @(posedge clk); #1;
    clear_err = 1'b0;
    check_state("clear_err_idle", ST_IDLE);
    check("clear_err_error", W'(error_o), W'(0));
    check("clear_err_trng_en", W'(trng_en), W'(0));
    @(posedge clk); #1;
    check_state("rewarm_entry", ST_WARMUP);
    check("rewarm_trng_en", W'(trng_en), W'(1));

    // enable dropped mid-word
    do_warmup(1'b0);
    for (int s = 0; s < 10; s++) send_sample(s[0]);
    enable = 1'b0;
    @(posedge clk); #1;
    check_state("disable_idle", ST_IDLE);
    check("disable_trng_en", W'(trng_en), W'(0));
    check("disable_valid", W'(sif.valid_o), W'(0));

    // asynchronous reset mid-COLLECT
    enable = 1'b1;
    @(posedge clk); #1;
    check_state("reenable_warmup", ST_WARMUP);
    do_warmup(1'b0);
    for (int s = 0; s < 5; s++) send_sample(s[0]);
    #3;
    rst = 1'b1;
    #1;
    check_state("async_rst_state", ST_IDLE);
    check("async_rst_trng_en", W'(trng_en), W'(0));
    check("async_rst_valid", W'(sif.valid_o), W'(0));
    check("async_rst_data", sif.data_o, W'(0));
    enable = 1'b0;
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    check_state("post_rst_idle", ST_IDLE);
    check("post_rst_trng_en", W'(trng_en), W'(0));

    // full warmup again before the first sample
    enable = 1'b1;
    @(posedge clk); #1;
    check_state("post_rst_warmup", ST_WARMUP);
    do_warmup(1'b0);
    exp_q.push_back(32'h0F0F_00FF);
    feed_word(32'h0F0F_00FF, 0);
    finish_word(32'h0F0F_00FF, "post_rst_word");
    check("scoreboard_empty", W'(exp_q.size()), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trng_ctrl.md
TRNG_CTRL -- requirements
Module: trng_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: output word width in bits.
REQ-002 Parameter SAMPLE_DIV, default 4: clk cycles between raw TRNG samples; legal range 2 or more.
REQ-003 Parameter WARMUP_CYCLES, default 256: clk cycles the oscillators run before sampling starts; legal range 1 or more.
REQ-004 Parameter REP_LIMIT, default 32: number of consecutive identical raw samples that trips the health test; legal range 2 or more.
REQ-005 clk  input  1  clock; the only clock; trng_out of the oscillator bank is already sampled in this domain.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 enable  input  1  level; 1 runs the generator, 0 returns it to IDLE.
REQ-008 clear_err  input  1  single-cycle pulse that leaves ERROR.
REQ-009 trng_bit  input  1  raw bit from the oscillator bank (its trng_out).
REQ-010 trng_en  output  1  oscillator enable (drives the bank's trng_en).
REQ-011 data_o  output  WIDTH  debiased random word.
REQ-012 valid_o  output  1  data_o holds a complete word.
REQ-013 ready_i  input  1  consumer accepts the word; transfer occurs when valid_o and ready_i are both 1 at a clk edge.
REQ-014 error_o  output  1  health-test failure flag.

Function
REQ-015 States: IDLE, WARMUP, COLLECT, HOLD, ERROR; all transitions occur on the clk rising edge.
REQ-016 IDLE: trng_en=0, valid_o=0; goes to WARMUP when enable=1.
REQ-017 WARMUP: trng_en=1; a counter runs WARMUP_CYCLES cycles, then the block goes to COLLECT with the divider, pair register, repetition counter and bit counter all cleared.
REQ-018 COLLECT: trng_en=1; a divider counts 0..SAMPLE_DIV-1 and, when it reaches SAMPLE_DIV-1, the sample strobe captures trng_bit, giving the first sample SAMPLE_DIV cycles after COLLECT is entered.
REQ-019 Von Neumann debiasing on consecutive non-overlapping sample pairs (first, second): 01 emits 0; 10 emits 1; 00 and 11 are discarded.
REQ-020 Emitted bits fill the word LSB-first: the first bit goes to bit 0 and the WIDTH-th bit to bit WIDTH-1.
REQ-021 The WIDTH-th emitted bit loads data_o and sets valid_o=1 in the next cycle, and the state becomes HOLD.
REQ-022 HOLD: sampling and the divider are frozen, trng_en stays 1, and data_o and valid_o stay stable until the transfer.
REQ-023 A transfer in HOLD gives valid_o=0 in the next cycle and a return to COLLECT with a cleared word, pair register and divider.
REQ-024 Health test, COLLECT only: a repetition counter counts raw samples equal to the previous raw sample; the reference is reset on COLLECT entry.
REQ-025 When a run of REP_LIMIT identical raw samples is reached, the next state is ERROR; this takes priority over word completion in the same cycle.
REQ-026 ERROR: trng_en=0, valid_o=0, error_o=1, and the partial word is discarded.
REQ-027 ERROR is left only by clear_err=1, which goes to IDLE with error_o=0 in the next cycle; enable has no effect in ERROR.
REQ-028 enable=0 in WARMUP, COLLECT or HOLD goes to IDLE in the next cycle; any pending word is dropped with valid_o=0, and this is the only case where valid_o falls without a transfer.
REQ-029 ready_i is ignored when valid_o=0; clear_err is ignored outside ERROR.
REQ-030 All counters are sized with the ceiling of log2 of their limit and never wrap; each is cleared on state entry.

Reset
REQ-031 rst=1 asynchronously forces IDLE with trng_en=0, valid_o=0, error_o=0, data_o=0 and all counters cleared, including in the middle of an operation.
REQ-032 After rst is released, the block takes no action until the first clk edge where enable=1.

Structure
REQ-033 A shared package trng_pkg holds the state enum type trng_state_t and the default parameter values.
REQ-034 One sub-module, trng_vn_debias, contains the pair register and the emit logic, with inputs strobe and raw bit and outputs bit_valid and bit.
REQ-035 The top level instantiates trng_128x7 only in integration wrappers; trng_ctrl itself sees only trng_en and trng_bit.

Verification
REQ-036 Default parameters, enable=1, trng_bit alternating 0 then 1 per sample -> trng_en=1 one cycle after enable, first strobe 256+4 cycles later, valid_o=1 with data_o=0x00000000 after 64 samples.
REQ-037 Pattern 1 then 0 per sample with ready_i=1 -> data_o=0xFFFFFFFF and a fresh word each 256 cycles plus handshake overhead.
REQ-038 trng_bit held at 1 -> error_o=1 and trng_en=0 after the 32nd identical sample; a clear_err pulse gives IDLE, then WARMUP again.
REQ-039 ready_i=0 for 100 cycles with a word pending -> data_o and valid_o stable, no strobes; ready_i=1 -> valid_o=0 next cycle.
REQ-040 enable=0 mid-word, then rst asserted mid-COLLECT -> IDLE, trng_en=0, no valid_o pulse; re-enable -> a full 256-cycle warmup before the first sample.
